// File: rtl/fft_frame_capture_pkg.sv
// Shared defaults and state encoding for the FFT frame capture block.
// Latency/backpressure: n/a (declarations only).
package fft_pkg;

    localparam int FFT_DATA_W      = 16;
    localparam int FFT_N_POINTS    = 1024;
    localparam int FFT_ADDR_W      = 10;
    localparam int FFT_LATENCY_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        READOUT = 3'd4
    } cap_state_t;

    // A latency of zero still needs a one-bit counter to keep the port legal.
    function automatic int lat_width(input int lat);
        return (lat > 0) ? $clog2(lat + 1) : 1;
    endfunction

endpackage

// File: rtl/fft_frame_capture_if.sv
// FFT output stream in, captured-frame readout out (valid/ready).
// slave = capture block, master = FFT driver plus readout consumer.
interface fft_frame_capture_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic                     enable;
    logic                     arm;
    logic signed [DATA_W-1:0] Xb_re;
    logic signed [DATA_W-1:0] Xb_im;
    logic                     busy;
    logic                     err;
    logic                     rd_valid;
    logic                     rd_ready;
    logic signed [DATA_W-1:0] rd_re;
    logic signed [DATA_W-1:0] rd_im;
    logic [ADDR_W-1:0]        rd_index;
    logic                     rd_last;
    logic                     done;

    modport master (
        output enable, arm, Xb_re, Xb_im, rd_ready,
        input  busy, err, rd_valid, rd_re, rd_im, rd_index, rd_last, done
    );

    modport slave (
        input  enable, arm, Xb_re, Xb_im, rd_ready,
        output busy, err, rd_valid, rd_re, rd_im, rd_index, rd_last, done
    );

endinterface

// File: rtl/fft_cap_ram.sv
// Simple dual-port frame RAM: one synchronous write port, one synchronous read port with enable.
// Read data appears one cycle after re; rdata holds while re is low. No reset on storage.
module fft_cap_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_frame_capture.sv
// Captures one latency-aligned FFT output frame, then replays it in bin order over valid/ready.
// First sample valid 2 cycles after the last write; 1 sample/cycle, holds while rd_ready is low.
module fft_frame_capture
    import fft_pkg::*;
#(
    parameter int DATA_W      = FFT_DATA_W,
    parameter int N_POINTS    = FFT_N_POINTS,
    parameter int ADDR_W      = FFT_ADDR_W,
    parameter int FFT_LATENCY = FFT_LATENCY_DEF
) (
    input logic                clk,
    input logic                rst,
    fft_frame_capture_if.slave bus
);

    localparam int                LAT_W     = lat_width(FFT_LATENCY);
    localparam logic [LAT_W-1:0]  LAT_END   = LAT_W'(FFT_LATENCY);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_POINTS - 1);
    localparam int                RAM_W     = 2 * DATA_W;

    cap_state_t        state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_more;
    logic              s1_vld;
    logic [ADDR_W-1:0] s1_idx;

    logic              start;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_sel;
    logic              pipe_adv;
    logic              rd_en;
    logic [RAM_W-1:0]  ram_q;

    always_comb begin
        start    = bus.enable && ((state == ARMED) || (state == IDLE && bus.arm));
        wr_en    = 1'b0;
        wr_sel   = wr_addr;
        case (state)
            IDLE, ARMED: begin
                wr_en  = start && (FFT_LATENCY == 0);
                wr_sel = '0;
            end
            WAIT: begin
                wr_en  = bus.enable && (lat_cnt == LAT_END);
                wr_sel = '0;
            end
            CAPTURE: wr_en = bus.enable;
            default: ;
        endcase
        // Two-stage read pipeline (RAM register, output register) advances as one unit.
        pipe_adv = (state == READOUT) && (!bus.rd_valid || bus.rd_ready);
        rd_en    = pipe_adv && rd_more;
    end

    fft_cap_ram #(
        .DATA_W (RAM_W),
        .DEPTH  (N_POINTS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_sel),
        .wdata ({bus.Xb_re, bus.Xb_im}),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            rd_more      <= 1'b0;
            s1_vld       <= 1'b0;
            s1_idx       <= '0;
            bus.busy     <= 1'b0;
            bus.err      <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_re    <= '0;
            bus.rd_im    <= '0;
            bus.rd_index <= '0;
            bus.rd_last  <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, ARMED: begin
                    if (state == IDLE) begin
                        rd_addr <= '0;
                        rd_more <= 1'b1;
                        s1_vld  <= 1'b0;
                        if (bus.arm) begin
                            bus.err  <= 1'b0;
                            bus.busy <= 1'b1;
                            state    <= ARMED;
                        end
                    end
                    if (start) begin
                        if (FFT_LATENCY == 0) begin
                            wr_addr <= ADDR_W'(1);
                            state   <= (N_POINTS == 1) ? READOUT : CAPTURE;
                        end else begin
                            lat_cnt <= LAT_W'(1);
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.enable) begin
                        state    <= IDLE;
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                    end else if (lat_cnt == LAT_END) begin
                        wr_addr <= ADDR_W'(1);
                        state   <= (N_POINTS == 1) ? READOUT : CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                CAPTURE: begin
                    if (!bus.enable) begin
                        state    <= IDLE;
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                    end else if (wr_addr == LAST_ADDR) begin
                        state <= READOUT;
                    end else begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                    end
                end
                READOUT: begin
                    if (pipe_adv) begin
                        if (rd_more) begin
                            s1_idx  <= rd_addr;
                            rd_more <= (rd_addr != LAST_ADDR);
                            if (rd_addr != LAST_ADDR) begin
                                rd_addr <= rd_addr + ADDR_W'(1);
                            end
                        end
                        s1_vld       <= rd_more;
                        bus.rd_valid <= s1_vld;
                        if (s1_vld) begin
                            bus.rd_re    <= ram_q[RAM_W-1:DATA_W];
                            bus.rd_im    <= ram_q[DATA_W-1:0];
                            bus.rd_index <= s1_idx;
                            bus.rd_last  <= (s1_idx == LAST_ADDR);
                        end
                    end
                    if (bus.rd_valid && bus.rd_ready && bus.rd_last) begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.rd_valid <= 1'b0;
                        bus.rd_last  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_capture.sv
// Bench for fft_frame_capture with an 8-point frame and latency 8.
// Expected bins are the samples driven at enable cycles LAT..LAT+N-1.
module tb_fft_frame_capture;

    localparam int DW  = 16;
    localparam int NP  = 8;
    localparam int AW  = 3;
    localparam int LAT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_frame_capture_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fft_frame_capture #(
        .DATA_W      (DW),
        .N_POINTS    (NP),
        .ADDR_W      (AW),
        .FFT_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] drv_re[$];
    logic [DW-1:0] drv_im[$];
    logic [DW-1:0] obs_re[$];
    logic [DW-1:0] obs_im[$];
    int            obs_idx[$];
    logic          obs_last[$];
    int            stall_viol;
    int            done_seen;
    int            done_vld_bad;
    int            cyc_used;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arm, then stream ncyc enable cycles; drop enable at drop_at, pulse arm at arm_at.
    task automatic drive_frame(input int ncyc, input int drop_at, input int arm_at, input bit ramp);
        logic [DW-1:0] re, im;
        drv_re.delete();
        drv_im.delete();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            if (k == drop_at) begin
                bus.enable = 1'b0;
                bus.arm    = 1'b0;
                step();
                return;
            end
            re = ramp ? DW'(k)  : DW'($urandom);
            im = ramp ? DW'(-k) : DW'($urandom);
            drv_re.push_back(re);
            drv_im.push_back(im);
            bus.enable = 1'b1;
            bus.Xb_re  = re;
            bus.Xb_im  = im;
            bus.arm    = (k == arm_at);
            step();
        end
        bus.enable = 1'b0;
        bus.arm    = 1'b0;
    endtask

    // Drains the readout port, recording handshakes; mode 0 ready, 1 = 1,0,0 pattern, 2 random.
    task automatic collect(input int mode, input int stop_idx, input int max_cyc);
        logic          rdy, held;
        logic [DW-1:0] s_re, s_im;
        logic [AW-1:0] s_idx;
        logic          s_last;
        obs_re.delete(); obs_im.delete(); obs_idx.delete(); obs_last.delete();
        stall_viol = 0; done_seen = 0; done_vld_bad = 0; cyc_used = max_cyc;
        for (int c = 0; c < max_cyc; c++) begin
            if (stop_idx >= 0 && bus.rd_valid === 1'b1 && int'(bus.rd_index) == stop_idx) begin
                bus.rd_ready = 1'b0;
                cyc_used = c;
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.rd_ready = rdy;
            s_re = bus.rd_re; s_im = bus.rd_im; s_idx = bus.rd_index; s_last = bus.rd_last;
            held = (bus.rd_valid === 1'b1) && !rdy;
            if (bus.rd_valid === 1'b1 && rdy) begin
                obs_re.push_back(bus.rd_re);
                obs_im.push_back(bus.rd_im);
                obs_idx.push_back(int'(bus.rd_index));
                obs_last.push_back(bus.rd_last);
            end
            step();
            if (held && (bus.rd_valid !== 1'b1 || bus.rd_re !== s_re || bus.rd_im !== s_im ||
                         bus.rd_index !== s_idx || bus.rd_last !== s_last))
                stall_viol++;
            if (bus.done === 1'b1) begin
                done_seen++;
                if (bus.rd_valid !== 1'b0) done_vld_bad++;
                bus.rd_ready = 1'b0;
                cyc_used = c + 1;
                return;
            end
        end
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        rst = 1'b0;
        step();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        checks++; if (bus.rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %b expected 0", bus.rd_last); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.rd_re !== '0 || bus.rd_im !== '0 || bus.rd_index !== '0) begin
            errors++; $display("FAIL reset_data: got re=%h im=%h idx=%0d expected 0", bus.rd_re, bus.rd_im, bus.rd_index);
        end
    endtask

    task automatic test_basic();
        drive_frame(LAT + NP, -1, -1, 1'b1);
        checks++; if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL basic_after_last_write: got busy=%b rd_valid=%b expected 1,0", bus.busy, bus.rd_valid);
        end
        step();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b expected 0", bus.rd_valid); end
        step();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_index !== '0) begin
            errors++; $display("FAIL basic_valid_rise: got valid=%b idx=%0d expected 1,0", bus.rd_valid, bus.rd_index);
        end
        collect(0, -1, 50);
        checks++; if (obs_re.size() != NP) begin errors++; $display("FAIL basic_count: got %0d expected %0d", obs_re.size(), NP); end
        for (int i = 0; i < obs_re.size() && i < NP; i++) begin
            checks++;
            if (obs_re[i] !== drv_re[LAT+i] || obs_im[i] !== drv_im[LAT+i] || obs_idx[i] != i || obs_last[i] !== (i == NP-1)) begin
                errors++;
                $display("FAIL basic_bin[%0d]: got re=%0d im=%0d idx=%0d last=%b expected re=%0d im=%0d idx=%0d last=%b",
                         i, $signed(obs_re[i]), $signed(obs_im[i]), obs_idx[i], obs_last[i],
                         $signed(drv_re[LAT+i]), $signed(drv_im[LAT+i]), i, (i == NP-1));
            end
        end
        checks++; if (cyc_used != NP) begin errors++; $display("FAIL basic_throughput: got %0d cycles expected %0d", cyc_used, NP); end
        checks++; if (done_seen != 1 || done_vld_bad != 0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_done: got done=%0d valid_with_done=%0d busy=%b expected 1,0,0", done_seen, done_vld_bad, bus.busy);
        end
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
    endtask

    task automatic test_backpressure(input int mode);
        drive_frame(LAT + NP, -1, -1, 1'b0);
        collect(mode, -1, 200);
        checks++; if (obs_re.size() != NP || done_seen != 1) begin
            errors++; $display("FAIL bp%0d_count: got %0d samples done=%0d expected %0d,1", mode, obs_re.size(), done_seen, NP);
        end
        for (int i = 0; i < obs_re.size() && i < NP; i++) begin
            checks++;
            if (obs_re[i] !== drv_re[LAT+i] || obs_im[i] !== drv_im[LAT+i] || obs_idx[i] != i) begin
                errors++;
                $display("FAIL bp%0d_bin[%0d]: got re=%h im=%h idx=%0d expected re=%h im=%h idx=%0d",
                         mode, i, obs_re[i], obs_im[i], obs_idx[i], drv_re[LAT+i], drv_im[LAT+i], i);
            end
        end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp%0d_stable: got %0d changes while stalled expected 0", mode, stall_viol); end
    endtask

    task automatic test_abort();
        bit seen_valid = 1'b0;
        drive_frame(LAT + NP, LAT + 3, -1, 1'b0);
        checks++; if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin
            errors++; $display("FAIL abort_state: got busy=%b err=%b expected 0,1", bus.busy, bus.err);
        end
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.rd_valid !== 1'b0) seen_valid = 1'b1;
        end
        bus.rd_ready = 1'b0;
        checks++; if (seen_valid) begin errors++; $display("FAIL abort_no_readout: got rd_valid=1 expected 0"); end
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL abort_rearm: got err=%b busy=%b expected 0,1", bus.err, bus.busy);
        end
        drive_frame(LAT + NP, -1, -1, 1'b0);
        collect(0, -1, 50);
        checks++; if (obs_re.size() != NP || obs_re[0] !== drv_re[LAT] || obs_im[NP-1] !== drv_im[LAT+NP-1]) begin
            errors++; $display("FAIL abort_next_frame: got %0d samples expected %0d matching bins", obs_re.size(), NP);
        end
    endtask

    task automatic test_arm_mid();
        drive_frame(LAT + NP, -1, LAT + 2, 1'b0);
        collect(0, -1, 50);
        checks++; if (obs_re.size() != NP || done_seen != 1 || bus.err !== 1'b0) begin
            errors++; $display("FAIL armmid_count: got %0d samples done=%0d err=%b expected %0d,1,0", obs_re.size(), done_seen, bus.err, NP);
        end
        for (int i = 0; i < obs_re.size() && i < NP; i++) begin
            checks++;
            if (obs_re[i] !== drv_re[LAT+i] || obs_im[i] !== drv_im[LAT+i]) begin
                errors++; $display("FAIL armmid_bin[%0d]: got re=%h im=%h expected re=%h im=%h", i, obs_re[i], obs_im[i], drv_re[LAT+i], drv_im[LAT+i]);
            end
        end
    endtask

    task automatic test_rst_readout();
        drive_frame(LAT + NP, -1, -1, 1'b0);
        collect(0, 4, 50);
        checks++; if (obs_re.size() != 4 || bus.rd_valid !== 1'b1) begin
            errors++; $display("FAIL rstro_prefix: got %0d samples valid=%b expected 4,1", obs_re.size(), bus.rd_valid);
        end
        rst = 1'b1;
        #1;
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_index !== '0 || bus.rd_re !== '0 || bus.rd_im !== '0 ||
                      bus.busy !== 1'b0 || bus.rd_last !== 1'b0) begin
            errors++; $display("FAIL rstro_async: got valid=%b idx=%0d re=%h im=%h busy=%b expected all 0",
                               bus.rd_valid, bus.rd_index, bus.rd_re, bus.rd_im, bus.busy);
        end
        #1;
        rst = 1'b0;
        step();
        drive_frame(LAT + NP, -1, -1, 1'b0);
        collect(0, -1, 50);
        checks++; if (obs_re.size() != NP || obs_idx[0] != 0) begin
            errors++; $display("FAIL rstro_recapture_count: got %0d samples expected %0d from index 0", obs_re.size(), NP);
        end
        for (int i = 0; i < obs_re.size() && i < NP; i++) begin
            checks++;
            if (obs_re[i] !== drv_re[LAT+i] || obs_im[i] !== drv_im[LAT+i] || obs_idx[i] != i) begin
                errors++; $display("FAIL rstro_bin[%0d]: got re=%h im=%h idx=%0d expected re=%h im=%h idx=%0d",
                                   i, obs_re[i], obs_im[i], obs_idx[i], drv_re[LAT+i], drv_im[LAT+i], i);
            end
        end
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.arm      = 1'b0;
        bus.Xb_re    = '0;
        bus.Xb_im    = '0;
        bus.rd_ready = 1'b0;
        rst          = 1'b0;
        test_reset();
        test_basic();
        test_backpressure(1);
        test_backpressure(2);
        test_abort();
        test_arm_mid();
        test_rst_readout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fft_frame_capture.md
Name: fft_frame_capture

Overview:
Sink-side companion to FFT_top: consumes the Xb_re/Xb_im output stream and captures one complete N-point frame into on-chip RAM. It then replays the frame in bin order over a valid/ready read port, for a host/readout interface or a bench checker. It replaces free-running sampling of FFT_top outputs with a deterministic, latency-aligned capture.

Parameters:
DATA_W, 16, width of each real/imag sample
N_POINTS, 1024, frame length (power of two)
ADDR_W, 10, log2(N_POINTS)
FFT_LATENCY, 1024, cycles from first enable-high cycle of the input frame to first valid FFT output bin

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
enable  in  1  same enable driven into FFT_top; high while a frame streams in
arm  in  1  single-cycle request to capture the next frame
Xb_re  in  DATA_W  FFT_top output, real, signed
Xb_im  in  DATA_W  FFT_top output, imag, signed
busy  out  1  high in ARMED, WAIT, CAPTURE, READOUT
err  out  1  sticky: enable dropped during WAIT/CAPTURE; cleared by arm or rst
rd_valid  out  1  readout sample valid
rd_ready  in  1  readout consumer ready
rd_re  out  DATA_W  readout sample, real
rd_im  out  DATA_W  readout sample, imag
rd_index  out  ADDR_W  bin index of current readout sample
rd_last  out  1  high with rd_valid on bin N_POINTS-1
done  out  1  one-cycle pulse after final readout handshake

Behaviour:
- Reset: state IDLE; busy, err, rd_valid, rd_last, done = 0; rd_re, rd_im, rd_index = 0; counters 0. RAM contents are not cleared.
- States:
  - IDLE: arm=1 -> ARMED, err cleared.
  - ARMED: first cycle with enable=1 -> WAIT, lat_cnt=1. If enable is already high when arm is seen, that cycle counts as the first.
  - WAIT: lat_cnt increments each cycle. When lat_cnt==FFT_LATENCY, that cycle's Xb is written to addr 0 -> CAPTURE, wr_addr=1.
  - CAPTURE: one sample written per cycle at wr_addr, incrementing. The write at addr N_POINTS-1 -> READOUT.
  - READOUT: rd_valid rises exactly 2 cycles after the final write (one cycle RAM read, one cycle output register), with rd_index=0. The data/index/last registers advance only on rd_valid&&rd_ready. They hold stable while rd_ready=0. With continuous ready, throughput is one sample per cycle, so RAM reads are prefetched. The handshake on rd_last -> IDLE with done=1 for one cycle and rd_valid=0 the same cycle.
- FFT_LATENCY=0: capture starts in the same cycle enable is first seen (ARMED goes directly to CAPTURE).
- enable=0 in any cycle of WAIT or CAPTURE: abort to IDLE, err=1. Partial data is discarded and no readout occurs. enable is ignored in READOUT.
- arm outside IDLE is ignored; it does not re-arm or clear err.
- Samples are stored bit-exact; no scaling, rounding or bit reversal (FFT_top output order is preserved).
- Counters: lat_cnt is clog2(FFT_LATENCY+1) bits and saturates. wr_addr/rd addr are ADDR_W bits and never wrap inside a frame.
- rst mid-operation returns immediately to reset values. The frame in progress is lost.

Decomposition:
- Shared package fft_pkg: DATA_W, N_POINTS, ADDR_W, FFT_LATENCY defaults, state encoding constants (IDLE, ARMED, WAIT, CAPTURE, READOUT).
- One sub-module, fft_cap_ram: simple dual-port RAM, N_POINTS x 2*DATA_W, one synchronous write port, one synchronous read port, no reset.

Test Plan:
- N_POINTS=8, FFT_LATENCY=8, arm, enable high 16 cycles, Xb_re=k, Xb_im=-k at cycle k after enable -> rd_re 8..15, rd_im -8..-15, rd_index 0..7, rd_last on index 7, done pulse, busy falls.
- Same setup, rd_ready toggled 1,0,0,1,... -> identical sequence; outputs stable while rd_ready=0; no sample skipped or duplicated.
- enable dropped at capture write 3 -> state IDLE, err=1, rd_valid never asserted; next arm clears err.
- arm pulsed during CAPTURE -> no effect; frame completes normally.
- rst asserted for one cycle mid-READOUT at rd_index=4 -> all outputs 0 immediately (async); re-arm captures a new frame from index 0.
- Default params, sin_10.mem frame as xb_re into FFT_top, output connected -> captured bins match output_re/output_im reference dumps exactly; peak magnitude at bins 10 and 1014.
